mul_issue_controller: RTL and testbench
=======================================

Name: mul_issue_controller

Overview:
- Sits between the execute-stage decode/operand path and Multiplier_Unit; directly upstream of it, and also consumes its result.
- Detects RV32M MUL/MULH/MULHSU/MULHU, latches the operands and accuracy control, and drives them stably to the multiplier.
- Tracks mul_unit_busy, stalls the pipeline until the product is captured, then presents a one-cycle result_valid.
- Holds a one-entry result cache so a repeated identical multiply completes without re-issuing.

Parameters:
- START_TIMEOUT, 2: cycles to wait for mul_unit_busy to rise before treating the multiplier output as a single-cycle (combinational) result.
- CACHE_EN, 1: 1 enables the one-entry result cache; 0 forces every multiply to issue.

Ports:
- CLK  in  1  core clock
- reset  in  1  synchronous, active-high reset
- ex_valid  in  1  execute stage holds a valid instruction
- ex_flush  in  1  abort any in-flight multiply
- opcode  in  7  instruction opcode
- funct7  in  7  instruction funct7
- funct3  in  3  instruction funct3
- accuracy_control  in  32  approximate-arithmetic control word
- rs1  in  32  operand 1
- rs2  in  32  operand 2
- stall  out  1  hold the execute stage
- result  out  32  product, valid when result_valid is high
- result_valid  out  1  one-cycle completion pulse
- mul_opcode  out  7  to Multiplier_Unit opcode
- mul_funct7  out  7  to Multiplier_Unit funct7
- mul_funct3  out  3  to Multiplier_Unit funct3
- mul_accuracy_control  out  32  to Multiplier_Unit accuracy_control
- mul_rs1  out  32  to Multiplier_Unit rs1
- mul_rs2  out  32  to Multiplier_Unit rs2
- mul_unit_busy  in  1  from Multiplier_Unit
- mul_output  in  32  from Multiplier_Unit

Behaviour:
- Multiply detection: is_mul = (opcode==7'b0110011) & (funct7==7'b0000001) & (funct3[2]==0).
  - DIV/REM (funct3[2]==1) and non-M ops are ignored: stall stays 0 and nothing is issued.
- stall is combinational: ex_valid & is_mul & ~result_valid.
- Reset: state=IDLE, result=0, result_valid=0, cache invalidated, all mul_* outputs 0.
- States are IDLE, ISSUE, WAIT and DONE.
  - IDLE: a new multiply is accepted only in this state, when ex_valid & is_mul.
    - Cache hit (CACHE_EN, entry valid, funct3/rs1/rs2/accuracy_control all equal): result loads the cached value; go to DONE. Latency is 1 cycle.
    - Miss: latch funct3/rs1/rs2/accuracy_control, clear the timeout counter, go to ISSUE.
  - ISSUE: drive the mul_* ports from the latched registers, with opcode 0110011 and funct7 0000001.
    - mul_unit_busy=1: go to WAIT.
    - Otherwise increment the counter. When it reaches START_TIMEOUT, capture mul_output and go to DONE.
  - WAIT: keep driving the latched operands. When mul_unit_busy falls to 0, capture mul_output that same cycle and go to DONE.
  - DONE: result_valid=1 for exactly one cycle; the cache is written with the operands and result (miss path only); go to IDLE.
- Outside ISSUE and WAIT, all mul_* outputs are 0, so the multiplier sees a non-M opcode.
- result holds its value until the next capture.
- ex_flush in any state: go to IDLE next cycle, suppress result_valid, do not write the cache, drive mul_* to 0. If ex_flush and accept occur in the same cycle, flush wins.
- reset mid-operation: same as flush, and the cache is also invalidated.
- Back-to-back multiplies: the instruction after DONE is accepted in the following IDLE cycle. Minimum issue-to-issue spacing is 2 cycles on a hit.
- Operands at the execute inputs may change while stalled; the latched copies are used.
- Arithmetic is entirely inside Multiplier_Unit. This block performs no width conversion.

Decomposition:
- Shared constants include: OPCODE_OP (7'b0110011), FUNCT7_MULDIV (7'b0000001), funct3 codes MUL/MULH/MULHSU/MULHU (000-011), and the state encodings.
- One natural sub-module, mul_result_cache:
  - Holds the valid bit, tag (funct3, rs1, rs2, accuracy_control) and data.
  - Provides lookup/hit, write and invalidate.

Test Plan:
1. MUL, rs1=500, rs2=55, accuracy_control=32'h7F9; multiplier model busy for 6 cycles -> stall high from accept through WAIT, result_valid pulses once, result=27500, mul_opcode returns to 0.
2. Same MUL repeated immediately -> cache hit, no mul_opcode activity, result_valid exactly 1 cycle after accept, result=27500.
3. Repeat with rs2=56 -> miss, issue, result=28000; then CACHE_EN=0 with a repeated op -> always issues.
4. Multiplier model never raises busy, combinational output 6000*7000 -> capture after START_TIMEOUT=2 cycles, result=42000000.
5. ex_flush during WAIT of a 6000*7000 MULHU -> no result_valid, stall 0 next cycle, identical re-issue misses the cache.
6. DIVU (funct3=101) and ADD (funct7=0) with ex_valid -> stall 0, mul_* all 0; reset asserted in ISSUE -> all outputs 0 next cycle.

Source files
------------

// File: rtl/mul_issue_controller_pkg.sv
// Shared constants, state encoding and operand tag type for the multiply issue controller.
package mul_issue_controller_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [6:0] OPCODE_OP     = 7'b0110011;
    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    typedef struct packed {
        logic [2:0]      funct3;
        logic [XLEN-1:0] acc;
        logic [XLEN-1:0] rs1;
        logic [XLEN-1:0] rs2;
    } mul_tag_t;

    // MUL/MULH/MULHSU/MULHU only; DIV/REM share funct7 but have funct3[2] set.
    function automatic logic is_mul_op(input logic [6:0] opc,
                                       input logic [6:0] f7,
                                       input logic [2:0] f3);
        return (opc == OPCODE_OP) && (f7 == FUNCT7_MULDIV) && !f3[2];
    endfunction

endpackage

// File: rtl/mul_result_cache.sv
// One-entry product cache tagged by funct3, operands and accuracy control.
module mul_result_cache
    import mul_issue_controller_pkg::*;
#(
    parameter bit EN = 1'b1
) (
    input  logic            clk,
    input  logic            invalidate,
    input  mul_tag_t        lookup_tag,
    output logic            hit_c,
    input  logic            wr_en,
    input  mul_tag_t        wr_tag,
    input  logic [XLEN-1:0] wr_data,
    output logic [XLEN-1:0] rd_data
);

    logic            valid_q, valid_d;
    mul_tag_t        tag_q, tag_d;
    logic [XLEN-1:0] data_q, data_d;

    always_comb begin
        valid_d = valid_q;
        tag_d   = tag_q;
        data_d  = data_q;
        if (invalidate) begin
            valid_d = 1'b0;
        end else if (wr_en && EN) begin
            valid_d = 1'b1;
            tag_d   = wr_tag;
            data_d  = wr_data;
        end
    end

    always_ff @(posedge clk) begin
        valid_q <= valid_d;
        tag_q   <= tag_d;
        data_q  <= data_d;
    end

    assign hit_c   = EN && valid_q && (tag_q == lookup_tag);
    assign rd_data = data_q;

endmodule

// File: rtl/mul_issue_controller.sv
// Issues RV32M multiplies to Multiplier_Unit, stalls execute until the product
// is captured, and short-circuits repeats through a one-entry result cache.
module mul_issue_controller
    import mul_issue_controller_pkg::*;
#(
    parameter int unsigned START_TIMEOUT = 2,
    parameter bit          CACHE_EN      = 1'b1
) (
    input  logic            CLK,
    input  logic            reset,
    input  logic            ex_valid,
    input  logic            ex_flush,
    input  logic [6:0]      opcode,
    input  logic [6:0]      funct7,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] accuracy_control,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    output logic            stall,
    output logic [XLEN-1:0] result,
    output logic            result_valid,
    output logic [6:0]      mul_opcode,
    output logic [6:0]      mul_funct7,
    output logic [2:0]      mul_funct3,
    output logic [XLEN-1:0] mul_accuracy_control,
    output logic [XLEN-1:0] mul_rs1,
    output logic [XLEN-1:0] mul_rs2,
    input  logic            mul_unit_busy,
    input  logic [XLEN-1:0] mul_output
);

    localparam int unsigned CNT_W = (START_TIMEOUT < 2) ? 1 : $clog2(START_TIMEOUT + 1);

    state_e          state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    mul_tag_t        lat_q, lat_d;
    logic            hit_q, hit_d;
    logic [XLEN-1:0] result_q, result_d;
    logic            result_valid_q, result_valid_d;
    logic [6:0]      mul_opcode_q, mul_opcode_d;
    logic [6:0]      mul_funct7_q, mul_funct7_d;
    logic [2:0]      mul_funct3_q, mul_funct3_d;
    logic [XLEN-1:0] mul_acc_q, mul_acc_d;
    logic [XLEN-1:0] mul_rs1_q, mul_rs1_d;
    logic [XLEN-1:0] mul_rs2_q, mul_rs2_d;

    mul_tag_t        in_tag_c;
    logic            is_mul_c;
    logic            accept_c;
    logic            cache_hit_c;
    logic            cache_wr_c;
    logic            issuing_c;
    logic [XLEN-1:0] cache_data;

    mul_result_cache #(
        .EN (CACHE_EN)
    ) u_cache (
        .clk        (CLK),
        .invalidate (reset),
        .lookup_tag (in_tag_c),
        .hit_c      (cache_hit_c),
        .wr_en      (cache_wr_c),
        .wr_tag     (lat_q),
        .wr_data    (result_q),
        .rd_data    (cache_data)
    );

    always_comb begin
        in_tag_c.funct3 = funct3;
        in_tag_c.acc    = accuracy_control;
        in_tag_c.rs1    = rs1;
        in_tag_c.rs2    = rs2;
        is_mul_c        = is_mul_op(opcode, funct7, funct3);
        accept_c        = ex_valid && is_mul_c;
    end

    assign stall = accept_c && !result_valid_q;

    // Next-state, capture and cache-write logic; flush overrides everything.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        lat_d      = lat_q;
        hit_d      = hit_q;
        result_d   = result_q;
        cache_wr_c = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (accept_c) begin
                    if (cache_hit_c) begin
                        result_d = cache_data;
                        hit_d    = 1'b1;
                        state_d  = ST_DONE;
                    end else begin
                        lat_d   = in_tag_c;
                        cnt_d   = '0;
                        hit_d   = 1'b0;
                        state_d = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: begin
                if (mul_unit_busy) begin
                    state_d = ST_WAIT;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_d == CNT_W'(START_TIMEOUT)) begin
                        result_d = mul_output;
                        state_d  = ST_DONE;
                    end
                end
            end
            ST_WAIT: begin
                if (!mul_unit_busy) begin
                    result_d = mul_output;
                    state_d  = ST_DONE;
                end
            end
            ST_DONE: begin
                cache_wr_c = !hit_q;
                state_d    = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        if (ex_flush) begin
            state_d    = ST_IDLE;
            result_d   = result_q;
            cache_wr_c = 1'b0;
        end

        result_valid_d = (state_d == ST_DONE);

        // Multiplier sees a non-M opcode unless an issue is in flight.
        issuing_c    = (state_d == ST_ISSUE) || (state_d == ST_WAIT);
        mul_opcode_d = issuing_c ? OPCODE_OP     : 7'd0;
        mul_funct7_d = issuing_c ? FUNCT7_MULDIV : 7'd0;
        mul_funct3_d = issuing_c ? lat_d.funct3  : 3'd0;
        mul_acc_d    = issuing_c ? lat_d.acc     : '0;
        mul_rs1_d    = issuing_c ? lat_d.rs1     : '0;
        mul_rs2_d    = issuing_c ? lat_d.rs2     : '0;
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            cnt_q          <= '0;
            lat_q          <= '0;
            hit_q          <= 1'b0;
            result_q       <= '0;
            result_valid_q <= 1'b0;
            mul_opcode_q   <= '0;
            mul_funct7_q   <= '0;
            mul_funct3_q   <= '0;
            mul_acc_q      <= '0;
            mul_rs1_q      <= '0;
            mul_rs2_q      <= '0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            lat_q          <= lat_d;
            hit_q          <= hit_d;
            result_q       <= result_d;
            result_valid_q <= result_valid_d;
            mul_opcode_q   <= mul_opcode_d;
            mul_funct7_q   <= mul_funct7_d;
            mul_funct3_q   <= mul_funct3_d;
            mul_acc_q      <= mul_acc_d;
            mul_rs1_q      <= mul_rs1_d;
            mul_rs2_q      <= mul_rs2_d;
        end
    end

    assign result               = result_q;
    assign result_valid         = result_valid_q;
    assign mul_opcode           = mul_opcode_q;
    assign mul_funct7           = mul_funct7_q;
    assign mul_funct3           = mul_funct3_q;
    assign mul_accuracy_control = mul_acc_q;
    assign mul_rs1              = mul_rs1_q;
    assign mul_rs2              = mul_rs2_q;

endmodule

// File: tb/tb_mul_issue_controller.sv
// Self-checking bench: behavioural Multiplier_Unit model plus a result scoreboard.
module tb_mul_issue_controller;
    import mul_issue_controller_pkg::*;

    logic        CLK = 1'b0;
    logic        reset, ex_valid, ex_valid1, ex_flush;
    logic [6:0]  opcode, funct7;
    logic [2:0]  funct3;
    logic [31:0] acc, rs1, rs2;

    logic        stall0, result_valid0, mul_unit_busy0;
    logic [31:0] result0, mul_acc0, mul_rs1_0, mul_rs2_0, mul_output0;
    logic [6:0]  mul_opcode0, mul_funct7_0;
    logic [2:0]  mul_funct3_0;

    logic        stall1, result_valid1;
    logic [31:0] result1, mul_acc1, mul_rs1_1, mul_rs2_1, mul_output1;
    logic [6:0]  mul_opcode1, mul_funct7_1;
    logic [2:0]  mul_funct3_1;

    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] sb[$];
    logic        rv_prev = 1'b0;

    bit          busy_mode = 1'b1;
    logic        m_busy = 1'b0;
    logic        m_started = 1'b0;
    int          m_cnt = 0;
    logic [31:0] m_out = 32'hDEAD_BEEF;

    always #5 CLK = ~CLK;

    mul_issue_controller #(.START_TIMEOUT(2), .CACHE_EN(1'b1)) dut0 (
        .CLK(CLK), .reset(reset), .ex_valid(ex_valid), .ex_flush(ex_flush),
        .opcode(opcode), .funct7(funct7), .funct3(funct3), .accuracy_control(acc),
        .rs1(rs1), .rs2(rs2), .stall(stall0), .result(result0), .result_valid(result_valid0),
        .mul_opcode(mul_opcode0), .mul_funct7(mul_funct7_0), .mul_funct3(mul_funct3_0),
        .mul_accuracy_control(mul_acc0), .mul_rs1(mul_rs1_0), .mul_rs2(mul_rs2_0),
        .mul_unit_busy(mul_unit_busy0), .mul_output(mul_output0));

    mul_issue_controller #(.START_TIMEOUT(2), .CACHE_EN(1'b0)) dut1 (
        .CLK(CLK), .reset(reset), .ex_valid(ex_valid1), .ex_flush(ex_flush),
        .opcode(opcode), .funct7(funct7), .funct3(funct3), .accuracy_control(acc),
        .rs1(rs1), .rs2(rs2), .stall(stall1), .result(result1), .result_valid(result_valid1),
        .mul_opcode(mul_opcode1), .mul_funct7(mul_funct7_1), .mul_funct3(mul_funct3_1),
        .mul_accuracy_control(mul_acc1), .mul_rs1(mul_rs1_1), .mul_rs2(mul_rs2_1),
        .mul_unit_busy(1'b0), .mul_output(mul_output1));

    function automatic logic [31:0] prod(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] ss, su, uu;
        ss = {{32{a[31]}}, a} * {{32{b[31]}}, b};
        su = {{32{a[31]}}, a} * {32'd0, b};
        uu = {32'd0, a} * {32'd0, b};
        case (f3)
            F3_MUL:    return ss[31:0];
            F3_MULH:   return ss[63:32];
            F3_MULHSU: return su[63:32];
            default:   return uu[63:32];
        endcase
    endfunction

    // Multiplier model: busy for 6 cycles after seeing an issue, or purely combinational.
    always @(posedge CLK) begin
        if (!busy_mode || mul_opcode0 != OPCODE_OP) begin
            m_busy    <= 1'b0;
            m_started <= 1'b0;
        end else if (!m_started) begin
            m_started <= 1'b1;
            m_busy    <= 1'b1;
            m_cnt     <= 6;
        end else if (m_busy) begin
            if (m_cnt == 1) begin
                m_busy <= 1'b0;
                m_out  <= prod(mul_funct3_0, mul_rs1_0, mul_rs2_0);
            end else begin
                m_cnt <= m_cnt - 1;
            end
        end
    end

    assign mul_unit_busy0 = m_busy;
    assign mul_output0    = busy_mode ? m_out : prod(mul_funct3_0, mul_rs1_0, mul_rs2_0);
    assign mul_output1    = prod(mul_funct3_1, mul_rs1_1, mul_rs2_1);

    // Scoreboard: every result_valid pops the oldest expected product.
    always @(negedge CLK) begin
        if (!reset && result_valid0) begin
            n_vec++;
            if (sb.size() == 0) begin
                n_err++;
                $display("FAIL sb_unexpected: result_valid with result=%0d, no product expected", result0);
            end else begin
                logic [31:0] e;
                e = sb.pop_front();
                if (result0 !== e) begin
                    n_err++;
                    $display("FAIL sb_result: got %0d expected %0d", result0, e);
                end
            end
            n_vec++;
            if (rv_prev !== 1'b0) begin
                n_err++;
                $display("FAIL rv_pulse_width: result_valid high for 2 consecutive cycles");
            end
        end
        rv_prev <= result_valid0;
    end

    task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] ac, input bit exp_issue, input int exp_lat, input string name);
        bit saw, stall_ok, done;
        int lat;
        @(posedge CLK); #1;
        opcode = OPCODE_OP; funct7 = FUNCT7_MULDIV; funct3 = f3;
        rs1 = a; rs2 = b; acc = ac; ex_valid = 1'b1;
        sb.push_back(prod(f3, a, b));
        saw = 1'b0; stall_ok = 1'b1; done = 1'b0; lat = 0;
        for (int c = 0; c < 40 && !done; c++) begin
            @(negedge CLK);
            if (mul_opcode0 != 7'd0) saw = 1'b1;
            if (result_valid0) begin
                done = 1'b1;
                lat  = c;
            end else if (stall0 !== 1'b1) begin
                stall_ok = 1'b0;
            end
        end
        if (!done) begin
            n_vec++; n_err++;
            $display("FAIL %s_timeout: no result_valid within 40 cycles", name);
        end else begin
            n_vec++;
            if (saw !== exp_issue) begin
                n_err++;
                $display("FAIL %s_issue: issued=%0b expected %0b", name, saw, exp_issue);
            end
            n_vec++;
            if (stall_ok !== 1'b1 || stall0 !== 1'b0) begin
                n_err++;
                $display("FAIL %s_stall: held=%0b at_done=%0b expected 1/0", name, stall_ok, stall0);
            end
            n_vec++;
            if (mul_opcode0 !== 7'd0) begin
                n_err++;
                $display("FAIL %s_mul_opcode_idle: got %b expected 0", name, mul_opcode0);
            end
            if (exp_lat >= 0) begin
                n_vec++;
                if (lat != exp_lat) begin
                    n_err++;
                    $display("FAIL %s_latency: got %0d expected %0d", name, lat, exp_lat);
                end
            end
        end
    endtask

    task automatic run_op1(input string name);
        bit saw, done;
        int lat;
        @(posedge CLK); #1;
        ex_valid1 = 1'b1;
        saw = 1'b0; done = 1'b0; lat = 0;
        for (int c = 0; c < 40 && !done; c++) begin
            @(negedge CLK);
            if (mul_opcode1 == OPCODE_OP && mul_funct7_1 == FUNCT7_MULDIV &&
                mul_acc1 == acc && stall1 == 1'b1) saw = 1'b1;
            if (result_valid1) begin
                done = 1'b1;
                lat  = c;
            end
        end
        n_vec++;
        if (!done || !saw || lat != 3) begin
            n_err++;
            $display("FAIL %s: done=%0b issued=%0b latency=%0d expected 1/1/3", name, done, saw, lat);
        end
        n_vec++;
        if (result1 !== prod(funct3, rs1, rs2)) begin
            n_err++;
            $display("FAIL %s_result: got %0d expected %0d", name, result1, prod(funct3, rs1, rs2));
        end
    endtask

    task automatic test_reset();
        @(negedge CLK);
        n_vec++;
        if ({stall0, result_valid0, result0, mul_opcode0, mul_funct7_0, mul_funct3_0,
             mul_acc0, mul_rs1_0, mul_rs2_0} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: rv=%0b result=%0d mul_opcode=%b expected all 0",
                     result_valid0, result0, mul_opcode0);
        end
        @(posedge CLK); #1;
        reset = 1'b0;
    endtask

    task automatic test_issue_and_cache();
        run_op(F3_MUL, 32'd500, 32'd55, 32'h7F9, 1'b1, -1, "busy_miss");
        run_op(F3_MUL, 32'd500, 32'd55, 32'h7F9, 1'b0, 1, "cache_hit");
        run_op(F3_MUL, 32'd500, 32'd56, 32'h7F9, 1'b1, -1, "tag_miss");
        ex_valid = 1'b0;
    endtask

    task automatic test_cache_disabled();
        run_op1("nocache_first");
        run_op1("nocache_repeat");
        ex_valid1 = 1'b0;
    endtask

    task automatic test_timeout();
        busy_mode = 1'b0;
        run_op(F3_MUL, 32'd6000, 32'd7000, 32'h0, 1'b1, 3, "timeout_comb");
        ex_valid = 1'b0;
        busy_mode = 1'b1;
    endtask

    task automatic test_flush();
        bit seen, rv_seen;
        @(posedge CLK); #1;
        opcode = OPCODE_OP; funct7 = FUNCT7_MULDIV; funct3 = F3_MULHU;
        rs1 = 32'd6000; rs2 = 32'd7000; acc = 32'h0; ex_valid = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge CLK);
            if (mul_unit_busy0) seen = 1'b1;
        end
        n_vec++;
        if (!seen) begin
            n_err++;
            $display("FAIL flush_wait_busy: busy never rose, expected 1");
        end
        @(posedge CLK); #1;
        ex_flush = 1'b1; ex_valid = 1'b0;
        @(posedge CLK); #1;
        ex_flush = 1'b0;
        @(negedge CLK);
        n_vec++;
        if (stall0 !== 1'b0 || mul_opcode0 !== 7'd0 || mul_rs1_0 !== 32'd0) begin
            n_err++;
            $display("FAIL flush_idle: stall=%0b mul_opcode=%b mul_rs1=%0d expected 0", stall0, mul_opcode0, mul_rs1_0);
        end
        rv_seen = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge CLK);
            if (result_valid0) rv_seen = 1'b1;
        end
        n_vec++;
        if (rv_seen !== 1'b0) begin
            n_err++;
            $display("FAIL flush_no_rv: result_valid=%0b after flush expected 0", rv_seen);
        end
        run_op(F3_MULHU, 32'd6000, 32'd7000, 32'h0, 1'b1, -1, "flush_reissue");
        ex_valid = 1'b0;
    endtask

    task automatic test_non_mul_and_reset();
        logic [2:0] f3s[2];
        logic [6:0] f7s[2];
        f3s[0] = 3'b101; f7s[0] = FUNCT7_MULDIV;
        f3s[1] = 3'b000; f7s[1] = 7'd0;
        for (int k = 0; k < 2; k++) begin
            bit bad;
            @(posedge CLK); #1;
            opcode = OPCODE_OP; funct7 = f7s[k]; funct3 = f3s[k];
            rs1 = 32'd9; rs2 = 32'd3; ex_valid = 1'b1;
            bad = 1'b0;
            for (int c = 0; c < 4; c++) begin
                @(negedge CLK);
                if (stall0 !== 1'b0 || mul_opcode0 !== 7'd0 || mul_rs1_0 !== 32'd0 || result_valid0 !== 1'b0)
                    bad = 1'b1;
            end
            n_vec++;
            if (bad) begin
                n_err++;
                $display("FAIL non_mul_%0d: stall=%0b mul_opcode=%b expected 0", k, stall0, mul_opcode0);
            end
        end
        ex_valid = 1'b0;
        run_op(F3_MUL, 32'd500, 32'd55, 32'h7F9, 1'b1, -1, "pre_reset");
        ex_valid = 1'b0;
        @(posedge CLK); #1;
        opcode = OPCODE_OP; funct7 = FUNCT7_MULDIV; funct3 = F3_MUL;
        rs1 = 32'd6000; rs2 = 32'd7000; acc = 32'h0; ex_valid = 1'b1;
        @(posedge CLK); #1;
        reset = 1'b1; ex_valid = 1'b0;
        @(negedge CLK);
        n_vec++;
        if (mul_opcode0 !== OPCODE_OP || mul_rs1_0 !== 32'd6000) begin
            n_err++;
            $display("FAIL reset_pre_issue: mul_opcode=%b mul_rs1=%0d expected 0110011/6000", mul_opcode0, mul_rs1_0);
        end
        @(posedge CLK); #1;
        @(negedge CLK);
        n_vec++;
        if ({stall0, result_valid0, result0, mul_opcode0, mul_funct7_0, mul_funct3_0,
             mul_acc0, mul_rs1_0, mul_rs2_0} !== '0) begin
            n_err++;
            $display("FAIL reset_mid_op: result=%0d mul_opcode=%b mul_rs1=%0d expected all 0",
                     result0, mul_opcode0, mul_rs1_0);
        end
        reset = 1'b0;
        run_op(F3_MUL, 32'd500, 32'd55, 32'h7F9, 1'b1, -1, "post_reset_miss");
        ex_valid = 1'b0;
    endtask

    initial begin
        reset = 1'b1; ex_valid = 1'b0; ex_valid1 = 1'b0; ex_flush = 1'b0;
        opcode = '0; funct7 = '0; funct3 = '0; acc = '0; rs1 = '0; rs2 = '0;
        repeat (3) @(posedge CLK);
        test_reset();
        test_issue_and_cache();
        test_cache_disabled();
        test_timeout();
        test_flush();
        test_non_mul_and_reset();
        repeat (3) @(negedge CLK);
        n_vec++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL sb_leftover: %0d products never completed, expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
